// File: rtl/ao486_l15_ifill_responder_pkg.sv
// L1.5 message-type encodings shared by the ao486 transducer and its L1.5 responder.
// Interrupt payload layout for the wake-up INT_RET.
package ao486_l15_ifill_responder_pkg;

    localparam logic [4:0] LOAD_RQ   = 5'b00000;
    localparam logic [4:0] IMISS_RQ  = 5'b10000;
    localparam logic [3:0] IFILL_RET = 4'b0001;
    localparam logic [3:0] INT_RET   = 4'b0111;

    localparam int         INT_TYPE_LSB   = 16;
    localparam logic [1:0] INT_TYPE_RESET = 2'b01;

    function automatic logic [63:0] int_wake_payload();
        logic [63:0] p;
        p = '0;
        p[INT_TYPE_LSB +: 2] = INT_TYPE_RESET;
        return p;
    endfunction

endpackage

// File: rtl/ao486_l15_ifill_responder_if.sv
// Transducer <-> L1.5 request/return bundle; master is the transducer, slave the L1.5 side.
interface ao486_l15_ifill_responder_if;

    logic        transducer_l15_val;
    logic [4:0]  transducer_l15_rqtype;
    logic [39:0] transducer_l15_address;
    logic        transducer_l15_req_ack;

    logic        l15_transducer_header_ack;
    logic        l15_transducer_val;
    logic [3:0]  l15_transducer_returntype;
    logic [63:0] l15_transducer_data_0;
    logic [63:0] l15_transducer_data_1;
    logic [63:0] l15_transducer_data_2;
    logic [63:0] l15_transducer_data_3;

    modport master (
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_address,
               transducer_l15_req_ack,
        input  l15_transducer_header_ack, l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0, l15_transducer_data_1, l15_transducer_data_2,
               l15_transducer_data_3
    );

    modport slave (
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_address,
               transducer_l15_req_ack,
        output l15_transducer_header_ack, l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0, l15_transducer_data_1, l15_transducer_data_2,
               l15_transducer_data_3
    );

endinterface

// File: rtl/ao486_l15_line_mem.sv
// MEM_LINES x 256-bit line store, 64-bit word writes, registered line read (1 cycle).
// No backpressure: the read register holds until the next rd_en/ld_en.
module ao486_l15_line_mem #(
    parameter int MEM_LINES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_LINES)-1:0] wr_line,
    input  logic [1:0]                   wr_word,
    input  logic [63:0]                  wr_dat,
    input  logic                         rd_en,
    input  logic [$clog2(MEM_LINES)-1:0] rd_line,
    input  logic                         ld_en,
    input  logic [255:0]                 ld_dat,
    output logic [255:0]                 rd_dat
);

    // Word 0 sits in the most significant 64 bits so the line reads big-endian.
    logic [0:3][63:0] mem_q [MEM_LINES];
    logic [0:3][63:0] rd_d;
    logic [0:3][63:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_line][wr_word] <= wr_dat;
        end
    end

    // A write landing in the read cycle is forwarded into the captured line.
    always_comb begin
        rd_d = mem_q[rd_line];
        if (wr_en && (wr_line == rd_line)) begin
            rd_d[wr_word] = wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (ld_en) begin
            rd_q <= ld_dat;
        end else if (rd_en) begin
            rd_q <= rd_d;
        end
    end

    assign rd_dat = rd_q;

endmodule

// File: rtl/ao486_l15_ifill_responder.sv
// L1.5 stand-in: wake-up INT_RET after reset, then IMISS_RQ -> IFILL_RET after RESP_LATENCY cycles.
// One request outstanding; returns held until req_ack, requests held off (no header_ack) until IDLE.
module ao486_l15_ifill_responder
    import ao486_l15_ifill_responder_pkg::*;
#(
    parameter int MEM_LINES    = 256,
    parameter int RESP_LATENCY = 4,
    parameter int WAKE_DELAY   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ao486_l15_ifill_responder_if.slave     l15,
    input  logic                           mem_wr_en,
    input  logic [$clog2(MEM_LINES)+1:0]   mem_wr_addr,
    input  logic [63:0]                    mem_wr_data,
    output logic [15:0]                    unsupported_cnt
);

    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int CNT_MAX = (WAKE_DELAY > RESP_LATENCY) ? WAKE_DELAY : RESP_LATENCY;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam int ST_W    = 3;

    typedef enum logic [ST_W-1:0] {
        BOOT_WAIT = 3'd0,
        INT_SEND  = 3'd1,
        IDLE      = 3'd2,
        WAIT_LAT  = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;
    logic             hdr_ack_q;
    logic             val_q;
    logic [3:0]       rtype_q;
    logic [15:0]      unsup_q;
    logic             rd_en;
    logic             ld_en;
    logic [255:0]     line_dat;

    // Line capture lands on the same edge that raises val, so data and val align.
    assign rd_en = (state_q == WAIT_LAT) && (cnt_q == '0);
    assign ld_en = (state_q == BOOT_WAIT) && (cnt_q == '0);

    ao486_l15_line_mem #(.MEM_LINES(MEM_LINES)) u_line_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_wr_en),
        .wr_line (mem_wr_addr[IDX_W+1:2]),
        .wr_word (mem_wr_addr[1:0]),
        .wr_dat  (mem_wr_data),
        .rd_en   (rd_en),
        .rd_line (idx_q),
        .ld_en   (ld_en),
        .ld_dat  ({int_wake_payload(), 192'd0}),
        .rd_dat  (line_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= BOOT_WAIT;
            cnt_q     <= CNT_W'(WAKE_DELAY - 1);
            idx_q     <= '0;
            hdr_ack_q <= 1'b0;
            val_q     <= 1'b0;
            rtype_q   <= '0;
            unsup_q   <= '0;
        end else begin
            hdr_ack_q <= 1'b0;
            case (state_q)
                BOOT_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= INT_SEND;
                        val_q   <= 1'b1;
                        rtype_q <= INT_RET;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                INT_SEND: begin
                    if (l15.transducer_l15_req_ack) begin
                        val_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    // The requester still shows val in the cycle after header_ack; don't re-accept it.
                    if (l15.transducer_l15_val && !hdr_ack_q) begin
                        hdr_ack_q <= 1'b1;
                        idx_q     <= l15.transducer_l15_address[5 +: IDX_W];
                        if (l15.transducer_l15_rqtype == IMISS_RQ) begin
                            state_q <= WAIT_LAT;
                            cnt_q   <= CNT_W'(RESP_LATENCY - 1);
                        end else if (unsup_q != 16'hFFFF) begin
                            unsup_q <= unsup_q + 16'd1;
                        end
                    end
                end
                WAIT_LAT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                        val_q   <= 1'b1;
                        rtype_q <= IFILL_RET;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (l15.transducer_l15_req_ack) begin
                        val_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign l15.l15_transducer_header_ack = hdr_ack_q;
    assign l15.l15_transducer_val        = val_q;
    assign l15.l15_transducer_returntype = rtype_q;
    assign l15.l15_transducer_data_0     = line_dat[255:192];
    assign l15.l15_transducer_data_1     = line_dat[191:128];
    assign l15.l15_transducer_data_2     = line_dat[127:64];
    assign l15.l15_transducer_data_3     = line_dat[63:0];
    assign unsupported_cnt               = unsup_q;

endmodule

// File: tb/tb_ao486_l15_ifill_responder.sv
// Scoreboarded bench for the L1.5 ifill responder: wake-up INT, fills, wrap, hold, unsupported, reset.
module tb_ao486_l15_ifill_responder;
    import ao486_l15_ifill_responder_pkg::*;

    localparam int RL = 4;
    localparam int WD = 16;

    typedef struct packed {
        logic [3:0]   rt;
        logic [255:0] d;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [63:0] mem_wr_data;
    logic [15:0] unsupported_cnt;

    ao486_l15_ifill_responder_if bus ();

    ao486_l15_ifill_responder #(
        .MEM_LINES    (256),
        .RESP_LATENCY (RL),
        .WAKE_DELAY   (WD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .l15             (bus.slave),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .unsupported_cnt (unsupported_cnt)
    );

    always #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    ret_t        exp_q[$];
    ret_t        cur;
    bit          in_ret = 1'b0;
    logic [63:0] model [256][4];
    int          exp_unsup = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Return monitor: pops an expectation on the first val cycle, then checks every held cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_ret = 1'b0;
        end else if (bus.l15_transducer_val) begin
            if (!in_ret) begin
                chk("ret_expected", 64'(exp_q.size() > 0), 64'd1);
                cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                in_ret = 1'b1;
            end
            chk("rtype",  64'(bus.l15_transducer_returntype), 64'(cur.rt));
            chk("data_0", bus.l15_transducer_data_0, cur.d[255:192]);
            chk("data_1", bus.l15_transducer_data_1, cur.d[191:128]);
            chk("data_2", bus.l15_transducer_data_2, cur.d[127:64]);
            chk("data_3", bus.l15_transducer_data_3, cur.d[63:0]);
        end else begin
            in_ret = 1'b0;
        end
    end

    task automatic push_int();
        ret_t e;
        e.rt = INT_RET;
        e.d  = {64'h0000_0000_0001_0000, 192'd0};
        exp_q.push_back(e);
    endtask

    task automatic bd_wr(input int line, input int word, input logic [63:0] dat);
        @(negedge clk);
        mem_wr_en   = 1'b1;
        mem_wr_addr = {line[7:0], word[1:0]};
        mem_wr_data = dat;
        model[line][word] = dat;
        @(posedge clk);
        #1 mem_wr_en = 1'b0;
    endtask

    // Released at a negedge, so the first rising edge after release is edge 1.
    task automatic boot_check();
        repeat (WD - 1) @(posedge clk);
        #1 chk("int_not_early", 64'(bus.l15_transducer_val), 64'd0);
        @(posedge clk);
        #1 chk("int_rise", 64'(bus.l15_transducer_val), 64'd1);
    endtask

    task automatic wait_val();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = bus.l15_transducer_val;
        end
        chk("val_seen", 64'(got), 64'd1);
    endtask

    task automatic consume(input int hold, input bit wr_in_resp);
        wait_val();
        if (wr_in_resp) bd_wr(3, 0, 64'hDEAD_BEEF_0BAD_F00D);
        repeat (hold) @(negedge clk);
        bus.transducer_l15_req_ack = 1'b1;
        @(posedge clk);
        #1 bus.transducer_l15_req_ack = 1'b0;
        @(negedge clk);
        chk("val_drop", 64'(bus.l15_transducer_val), 64'd0);
    endtask

    task automatic do_req(input logic [4:0] rq, input logic [39:0] addr,
                          input bit late_wr, input int lw_word, input logic [63:0] lw_dat);
        ret_t e;
        int   ln;
        int   lat;
        bit   got;
        ln = int'((addr >> 5) % 40'd256);
        if (late_wr) model[ln][lw_word] = lw_dat;
        if (rq == IMISS_RQ) begin
            e.rt = IFILL_RET;
            e.d  = {model[ln][0], model[ln][1], model[ln][2], model[ln][3]};
            exp_q.push_back(e);
        end else begin
            exp_unsup++;
        end
        @(negedge clk);
        bus.transducer_l15_val     = 1'b1;
        bus.transducer_l15_rqtype  = rq;
        bus.transducer_l15_address = addr;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = bus.l15_transducer_header_ack;
        end
        chk("hdr_ack_seen", 64'(got), 64'd1);
        chk("hdr_ack_no_val", 64'(bus.l15_transducer_val), 64'd0);
        lat = -1;
        for (int k = 1; k <= RL + 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus.transducer_l15_val = 1'b0;
            mem_wr_en   = late_wr && (k == RL - 1);
            mem_wr_addr = {ln[7:0], lw_word[1:0]};
            mem_wr_data = lw_dat;
            @(negedge clk);
            if (k == 1) chk("hdr_ack_pulse", 64'(bus.l15_transducer_header_ack), 64'd0);
            if (bus.l15_transducer_val && lat < 0) lat = k;
        end
        chk("latency", 64'(lat), (rq == IMISS_RQ) ? 64'(RL) : 64'(-1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_wr_en = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        bus.transducer_l15_val     = 1'b0;
        bus.transducer_l15_rqtype  = '0;
        bus.transducer_l15_address = '0;
        bus.transducer_l15_req_ack = 1'b0;

        // Wake-up interrupt, held while req_ack is low, issued once.
        repeat (3) @(negedge clk);
        chk("rst_val", 64'(bus.l15_transducer_val), 64'd0);
        chk("rst_hdr_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
        chk("rst_unsup", 64'(unsupported_cnt), 64'd0);
        push_int();
        rst_n = 1'b1;
        boot_check();
        consume(3, 1'b0);
        repeat (20) @(negedge clk);
        chk("no_second_int", 64'(bus.l15_transducer_val), 64'd0);

        // Line 3 fill, word order on data_0..3.
        bd_wr(3, 0, 64'h0011223344556677);
        bd_wr(3, 1, 64'h8899AABBCCDDEEFF);
        bd_wr(3, 2, 64'h0102030405060708);
        bd_wr(3, 3, 64'h1112131415161718);
        do_req(IMISS_RQ, 40'h000000006F, 1'b0, 0, 64'd0);
        consume(1, 1'b0);

        // Long hold with a backdoor write to the presented line during RESP.
        do_req(IMISS_RQ, 40'h000000006F, 1'b0, 0, 64'd0);
        consume(10, 1'b1);

        // Address beyond MEM_LINES wraps to line 3; ack in the first val cycle.
        do_req(IMISS_RQ, 40'h0000002060, 1'b0, 0, 64'd0);
        consume(0, 1'b0);

        // Write to the in-flight line on the last WAIT_LAT cycle shows in the return.
        bd_wr(4, 0, 64'hA0A1A2A3A4A5A6A7);
        bd_wr(4, 1, 64'hB0B1B2B3B4B5B6B7);
        bd_wr(4, 2, 64'hC0C1C2C3C4C5C6C7);
        bd_wr(4, 3, 64'hD0D1D2D3D4D5D6D7);
        do_req(IMISS_RQ, 40'h0000000080, 1'b1, 2, 64'hCAFE_F00D_1234_5678);
        consume(2, 1'b0);

        // Unsupported request: acked, no return, counter bumps.
        chk("unsup_before", 64'(unsupported_cnt), 64'(exp_unsup));
        do_req(LOAD_RQ, 40'h0000001000, 1'b0, 0, 64'd0);
        chk("unsup_after", 64'(unsupported_cnt), 64'(exp_unsup));

        // Reset in the middle of a held return, then the wake-up replays.
        do_req(IMISS_RQ, 40'h0000000080, 1'b0, 0, 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_val", 64'(bus.l15_transducer_val), 64'd0);
        chk("rst_mid_hdr_ack", 64'(bus.l15_transducer_header_ack), 64'd0);
        chk("rst_mid_unsup", 64'(unsupported_cnt), 64'd0);
        chk("rst_mid_data_0", bus.l15_transducer_data_0, 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        push_int();
        rst_n = 1'b1;
        boot_check();
        consume(0, 1'b0);
        repeat (10) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ao486_l15_ifill_responder.md
Name: ao486_l15_ifill_responder

Overview:
L1.5-side responder for the ao486 transducer's request/return interface. It is the counterpart of the transducer's IMISS initiator.
- After reset it issues the one-shot wake-up interrupt that releases the core.
- It accepts IMISS_RQ requests with a one-cycle header_ack.
- After a fixed latency it returns a 32-byte IFILL_RET line from an internal line memory.
- Used in tile-level unit benches and FPGA bring-up in place of the real L1.5.

Parameters:
MEM_LINES, 256, number of 32-byte lines in the line memory (power of two)
RESP_LATENCY, 4, cycles from header_ack to first return-valid cycle (min 1)
WAKE_DELAY, 16, cycles after reset deassertion before the INT_RET wake-up is presented

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
transducer_l15_val  in  1  request valid, held until header_ack
transducer_l15_rqtype  in  5  request type
transducer_l15_address  in  40  request address; bits [4:0] ignored
transducer_l15_req_ack  in  1  return consumed
l15_transducer_header_ack  out  1  request accepted (one-cycle pulse)
l15_transducer_val  out  1  return valid
l15_transducer_returntype  out  4  IFILL_RET or INT_RET
l15_transducer_data_0  out  64  line bytes 0-7, or interrupt payload
l15_transducer_data_1  out  64  line bytes 8-15
l15_transducer_data_2  out  64  line bytes 16-23
l15_transducer_data_3  out  64  line bytes 24-31
mem_wr_en  in  1  backdoor write strobe
mem_wr_addr  in  $clog2(MEM_LINES)+2  line index and 64-bit word select
mem_wr_data  in  64  backdoor write data, big-endian
unsupported_cnt  out  16  count of accepted non-IMISS requests, saturating

Behaviour:
- All outputs are registered. Reset (async, rst_n=0) clears every output to 0, the state to BOOT_WAIT, all counters, and any pending request. Line memory contents are not reset.
- States:
  - BOOT_WAIT: count WAKE_DELAY cycles, then go to INT_SEND.
  - INT_SEND: present val=1, returntype=INT_RET, data_0[17:16]=2'b01, other data 0. Hold until req_ack is sampled high, then go to IDLE. This happens exactly once per reset.
  - IDLE: if transducer_l15_val=1, pulse header_ack for one cycle and latch rqtype and address[39:5].
    - rqtype=IMISS_RQ: go to WAIT_LAT.
    - Any other rqtype: increment unsupported_cnt (saturating at 16'hFFFF), produce no return, stay in IDLE.
  - WAIT_LAT: count down RESP_LATENCY-1 cycles, read the line, go to RESP.
  - RESP: present val=1, returntype=IFILL_RET, data_0..3 = line[addr[5+:$clog2(MEM_LINES)]]. Addresses wrap modulo MEM_LINES. Hold all outputs stable until req_ack is sampled high. On the next cycle drop val and go to IDLE.
- Latency: the first return-valid cycle is exactly RESP_LATENCY cycles after the header_ack cycle.
- Only one request is outstanding at a time. header_ack is never asserted outside IDLE, and never in the same cycle as val.
- A request arriving during BOOT_WAIT or INT_SEND is not acknowledged until IDLE, so the interrupt always precedes the first fill.
- If req_ack is high in the first cycle val is high, the return completes after one cycle.
- req_ack while val=0 is ignored.
- Backdoor writes:
  - Legal in any state; they write word mem_wr_addr[1:0] of line mem_wr_addr[msb:2].
  - A write to the line in flight during WAIT_LAT is visible in the return. The line is read on the last WAIT_LAT cycle.
  - A write during RESP does not alter the presented data.
- Data format: data_N[63:56] holds line byte 8N (big-endian). The line is stored exactly as written.

Decomposition:
- Shared package/defines: IMISS_RQ, IFILL_RET, INT_RET and the interrupt payload field position [17:16]. These reuse the codebase's existing L1.5 message-type defines and are not redefined here.
- Local state encoding is a localparam.
- Sub-module ao486_l15_line_mem holds the MEM_LINES x 256-bit array, with a 64-bit word-granular write port and a registered 256-bit line read port.

Test Plan:
1. Reset, idle inputs -> val rises exactly WAKE_DELAY cycles after rst_n deassert, with returntype=INT_RET, data_0=64'h0000_0000_0001_0000. Output holds until req_ack, then val=0; no second INT.
2. Backdoor load line 3 with words 64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0102030405060708, 64'h1112131415161718; request IMISS_RQ at address 40'h000000006F -> header_ack one cycle, and val RESP_LATENCY cycles later with data_0..3 equal to those words in order.
3. Hold req_ack low for 10 cycles during RESP -> val and data stable for all 10 cycles. Then req_ack=1 -> val=0 on the next cycle, and the next request is acked.
4. Request address 40'h0000002060 with MEM_LINES=256 -> returns line 3, confirming wrap.
5. Request with rqtype=LOAD_RQ -> header_ack pulses, no val, unsupported_cnt 0->1.
6. Assert rst_n=0 during RESP -> val, header_ack and unsupported_cnt go to 0 immediately. After release the INT_RET sequence repeats.
